// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default widths, the bubble instruction and the stall-counter helper.
package if_fetch_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam int          STALL_CNT_W   = 32;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] value);
        if (value == STALL_CNT_MAX) begin
            return value;
        end
        return value + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    // Fetch unit side: issues requests, receives single-cycle ack pulses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory / I-cache side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: pc/instr/valid with synchronous clear, load
// enable, and a bubble control that loads a NOP with valid cleared.
module if_fetch_unit_ifid_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              valid
);

    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] instr_reg;
    logic              valid_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            // A bubble still records the squashed PC so the slot stays traceable.
            pc_reg    <= pc_in;
            instr_reg <= bubble ? NOP_INSTR : instr_in;
            valid_reg <= ~bubble;
        end
    end

    assign pc    = pc_reg;
    assign instr = instr_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: req/ack handshake with instruction memory, IF/ID
// update with hazard hold and branch flush, and a saturating stall counter.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      pc_i,
    input  logic                   hazard_stall_i,
    input  logic                   flush_i,
    if_fetch_unit_if.master        imem,
    output logic                   stall_o,
    output logic [ADDR_W-1:0]      pc_plus4_o,
    output logic [ADDR_W-1:0]      ifid_pc_o,
    output logic [DATA_W-1:0]      ifid_instr_o,
    output logic                   ifid_valid_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    fetch_state_e           state_reg;
    fetch_state_e           state_next;
    logic                   req_reg;
    logic [ADDR_W-1:0]      hold_pc_reg;
    logic [DATA_W-1:0]      hold_instr_reg;
    logic [STALL_CNT_W-1:0] stall_cycles_reg;

    logic                   ack_seen;
    logic                   hold_capture;
    logic                   hold_drop;
    logic                   ifid_load;
    logic                   ifid_bubble;
    logic [ADDR_W-1:0]      ifid_pc_in;
    logic [DATA_W-1:0]      ifid_instr_in;

    // The address follows the PC directly; the stall keeps the PC frozen
    // until the ack, which is what keeps the address stable.
    assign imem.imem_addr = pc_i;
    assign imem.imem_req  = req_reg;
    assign pc_plus4_o     = pc_i + ADDR_W'(4);

    // An ack only counts while a request is actually outstanding.
    assign ack_seen = req_reg & imem.imem_ack;
    assign stall_o  = req_reg & ~imem.imem_ack;

    always_comb begin
        state_next    = state_reg;
        hold_capture  = 1'b0;
        hold_drop     = 1'b0;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_pc_in    = pc_i;
        ifid_instr_in = imem.imem_rdata;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (ack_seen) begin
                    if (flush_i) begin
                        ifid_load   = 1'b1;
                        ifid_bubble = 1'b1;
                    end else if (hazard_stall_i) begin
                        hold_capture = 1'b1;
                        state_next   = ST_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                // Replay from the buffer; the live PC may already have moved on.
                ifid_pc_in    = hold_pc_reg;
                ifid_instr_in = hold_instr_reg;
                if (flush_i) begin
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                    hold_drop   = 1'b1;
                    state_next  = ST_FETCH;
                end else if (!hazard_stall_i) begin
                    ifid_load  = 1'b1;
                    hold_drop  = 1'b1;
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= ST_IDLE;
            req_reg          <= 1'b0;
            hold_pc_reg      <= '0;
            hold_instr_reg   <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= (state_next == ST_FETCH);

            if (hold_capture) begin
                hold_pc_reg    <= pc_i;
                hold_instr_reg <= imem.imem_rdata;
            end else if (hold_drop) begin
                hold_pc_reg    <= '0;
                hold_instr_reg <= '0;
            end

            if (stall_o) begin
                stall_cycles_reg <= sat_inc(stall_cycles_reg);
            end
        end
    end

    assign stall_cycles_o = stall_cycles_reg;

    if_fetch_unit_ifid_reg #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk_i),
        .clear    (rst_i),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_in    (ifid_pc_in),
        .instr_in (ifid_instr_in),
        .pc       (ifid_pc_o),
        .instr    (ifid_instr_o),
        .valid    (ifid_valid_o)
    );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Each cycle it takes the current PC and runs a req/ack handshake to instruction memory or the I-cache.
- It writes the returned instruction into the IF/ID pipeline register, honouring hazard stalls and branch flushes.
- It drives stall_o back to the PC's stall input and to the rest of the pipeline while a fetch is outstanding.

Parameters:
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- NOP_INSTR, 32'h00000000, bubble written into IF/ID on flush and reset

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  CPU start; fetching begins after first high sample
- pc_i  in  ADDR_W  current PC (from PC register)
- hazard_stall_i  in  1  load-use hazard: hold IF/ID and do not consume a new instruction
- flush_i  in  1  branch taken in ID: squash the instruction entering IF/ID
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  fetch address, equal to pc_i (combinational)
- imem_ack_i  in  1  data valid, single-cycle pulse
- imem_rdata_i  in  DATA_W  fetched instruction, valid when imem_ack_i=1
- stall_o  out  1  global fetch stall (to PC stall_i and pipeline registers)
- pc_plus4_o  out  ADDR_W  pc_i+4, modulo 2^ADDR_W (combinational)
- ifid_pc_o  out  ADDR_W  IF/ID PC field
- ifid_instr_o  out  DATA_W  IF/ID instruction field
- ifid_valid_o  out  1  IF/ID holds a real instruction
- stall_cycles_o  out  32  count of cycles with stall_o=1, saturating

Behaviour:
- Reset (rst_i=1 at a clock edge) is synchronous and active-high. It sets:
  - state IDLE; imem_req_o=0; stall_o=0
  - ifid_instr_o=NOP_INSTR, ifid_pc_o=0, ifid_valid_o=0
  - hold buffer cleared; stall_cycles_o=0
- Reset asserted mid-fetch abandons the outstanding request. Any later imem_ack_i is ignored while in IDLE.
- IDLE:
  - imem_req_o=0, stall_o=0.
  - start_i=1 moves to FETCH next cycle.
  - start_i is ignored outside IDLE.
- FETCH:
  - imem_req_o=1.
  - Handshake rule: address stays stable until ack, because stall_o holds the PC.
  - imem_ack_i=0: stall_o=1 and state stays FETCH.
  - imem_ack_i=1: stall_o=0 in that same cycle, so the PC advances at the next edge. IF/ID is then updated at that edge by priority:
    1. flush_i=1: NOP_INSTR, valid=0, ifid_pc_o=pc_i; stay FETCH.
    2. hazard_stall_i=1: IF/ID unchanged; imem_rdata_i and pc_i go to the hold buffer; go HOLD.
    3. Otherwise: instr=imem_rdata_i, pc=pc_i, valid=1; stay FETCH, so back-to-back fetch is 1 instruction/cycle on a zero-wait ack.
- HOLD:
  - imem_req_o=0 and stall_o=0; the hazard unit owns PC write.
  - flush_i=1: bubble into IF/ID, drop the buffer, go FETCH.
  - Else if hazard_stall_i=0: buffer contents go into IF/ID with valid=1; go FETCH.
  - Else remain in HOLD.
- Latency: ack to IF/ID output is 1 clock edge.
- imem_ack_i is ignored whenever imem_req_o=0.
- stall_cycles_o increments by 1 per cycle with stall_o=1 and saturates at 32'hFFFFFFFF.
- pc_plus4_o wraps: 32'hFFFFFFFC → 0.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state encoding: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2
  - NOP_INSTR constant
  - ADDR_W/DATA_W defaults
- One natural sub-module: ifid_reg.
  - Holds the pc/instr/valid pipeline register.
  - Inputs: synchronous clear, load enable and bubble control.
  - It is reused for the IF/ID flush path.

Test Plan:
- Reset then start_i=1, ack every cycle, pc_i 0,4,8 with rdata A,B,C → IF/ID shows (0,A,1),(4,B,1),(8,C,1) on consecutive cycles; stall_o stays 0.
- Ack delayed 3 cycles at pc_i=0x10 → stall_o=1 for 3 cycles; imem_addr_o=0x10 held; IF/ID gets (0x10,rdata,1) one edge after ack; stall_cycles_o=3.
- Ack together with hazard_stall_i=1 for 2 cycles → IF/ID unchanged 2 cycles, state HOLD, no req; then the buffered instr appears with valid=1.
- flush_i=1 in the ack cycle at pc_i=0x20 → ifid_instr_o=NOP_INSTR, ifid_valid_o=0; next fetch proceeds normally.
- rst_i=1 while in FETCH awaiting ack, then ack arrives → all outputs at reset values; the ack is ignored; restart requires start_i.
- pc_i=32'hFFFFFFFC → pc_plus4_o=0; stall saturation checked by forcing the counter to 32'hFFFFFFFE and stalling 3 cycles → holds 32'hFFFFFFFF.
